// File: rtl/mips_control_signal_memory_pkg.sv
// Memory control-word constants shared by decode and the MEM stage.
package mips_control_signal_memory_pkg;

  typedef enum logic [1:0] {
    BYTE_ENABLE_NONE = 2'd0,
    BYTE_ENABLE_BYTE = 2'd1,
    BYTE_ENABLE_HALF = 2'd2,
    BYTE_ENABLE_WORD = 2'd3
  } byte_enable_e;

  typedef enum logic {
    BYTE_EXTEND_UNSIGNED = 1'b0,
    BYTE_EXTEND_SIGNED   = 1'b1
  } byte_extend_e;

endpackage

// File: rtl/mips_memory_stage_access_pkg.sv
// MEM-stage access types: FSM states, timeout counter sizing, lane helpers.
package mips_memory_stage_access_pkg;
  import mips_control_signal_memory_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // A zero timeout still needs a 1-bit counter to keep the declaration legal.
  function automatic int unsigned timeout_count_width(input int unsigned cycles);
    if (cycles == 0) return 1;
    return $clog2(cycles + 1);
  endfunction

  function automatic logic [3:0] lane_mask(input byte_enable_e size, input logic [1:0] lane);
    case (size)
      BYTE_ENABLE_BYTE: return 4'b0001 << lane;
      BYTE_ENABLE_HALF: return 4'b0011 << lane;
      BYTE_ENABLE_WORD: return 4'b1111;
      default:          return '0;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input byte_enable_e size, input logic [31:0] data);
    case (size)
      BYTE_ENABLE_BYTE: return {4{data[7:0]}};
      BYTE_ENABLE_HALF: return {2{data[15:0]}};
      BYTE_ENABLE_WORD: return data;
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_memory_stage_lane.sv
// Byte-lane steering: request mask/replicated store data, and response extract/extend.
module mips_memory_stage_lane
  import mips_control_signal_memory_pkg::*;
  import mips_memory_stage_access_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_lane,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_mask,
  output logic [31:0] write_data,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_lane,
  input  logic        rsp_extend,
  input  logic [31:0] read_data,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sign_fill;

  always_comb begin
    byte_mask  = lane_mask(byte_enable_e'(req_size), req_lane);
    write_data = lane_replicate(byte_enable_e'(req_size), store_data);
  end

  always_comb begin
    case (rsp_lane)
      2'd0:    sel_byte = read_data[7:0];
      2'd1:    sel_byte = read_data[15:8];
      2'd2:    sel_byte = read_data[23:16];
      default: sel_byte = read_data[31:24];
    endcase
    // Halfword accesses are always even-aligned, so only lane bit 1 matters.
    sel_half  = rsp_lane[1] ? read_data[31:16] : read_data[15:0];
    sign_fill = (rsp_extend == BYTE_EXTEND_SIGNED);
    case (rsp_size)
      BYTE_ENABLE_BYTE: load_data = {{24{sign_fill & sel_byte[7]}}, sel_byte};
      BYTE_ENABLE_HALF: load_data = {{16{sign_fill & sel_half[15]}}, sel_half};
      BYTE_ENABLE_WORD: load_data = read_data;
      default:          load_data = '0;
    endcase
  end

endmodule

// File: rtl/mips_memory_stage_access.sv
// MEM-stage data-memory access unit: request/ready bus master that stalls the
// pipeline for the duration of each load/store and returns extended load data.
module mips_memory_stage_access
  import mips_control_signal_memory_pkg::*;
  import mips_memory_stage_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic        flush,
  input  logic        writeEnable,
  input  logic [1:0]  byteEnable,
  input  logic        byteExtend,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        memRequest,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [3:0]  memByteMask,
  output logic [31:0] memWriteData,
  input  logic        memReady,
  input  logic [31:0] memReadData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        doneValid,
  output logic        misaligned,
  output logic        busError
);

  localparam int unsigned CW = timeout_count_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] COUNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] count_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic          extend_q;

  logic          access;
  logic          accept;
  logic          ready_hit;
  logic          timed_out;
  logic [3:0]    mask_next;
  logic [31:0]   wdata_next;
  logic [31:0]   extracted;

  always_comb begin
    access     = inValid & (byteEnable != BYTE_ENABLE_NONE) & ~flush;
    misaligned = access & (((byteEnable == BYTE_ENABLE_HALF) & address[0]) |
                           ((byteEnable == BYTE_ENABLE_WORD) & (address[1:0] != 2'b00)));
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    accept    = 1'b0;
    ready_hit = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !misaligned) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        // A response arriving on the final allowed cycle beats the timeout.
        if (memReady) begin
          ready_hit = 1'b1;
          state_d   = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (count_q == COUNT_LAST)) begin
          timed_out = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      size_q       <= '0;
      lane_q       <= '0;
      extend_q     <= 1'b0;
      memRequest   <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= '0;
      memByteMask  <= '0;
      memWriteData <= '0;
      loadData     <= '0;
      doneValid    <= 1'b0;
      busError     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= (state_q == ST_BUSY && state_d == ST_BUSY) ? count_q + CW'(1) : '0;
      doneValid <= ready_hit | timed_out;
      busError  <= timed_out;
      if (accept) begin
        memRequest   <= 1'b1;
        memWrite     <= writeEnable;
        memAddress   <= {address[31:2], 2'b00};
        memByteMask  <= mask_next;
        memWriteData <= wdata_next;
        size_q       <= byteEnable;
        lane_q       <= address[1:0];
        extend_q     <= byteExtend;
      end
      if (ready_hit) begin
        memRequest <= 1'b0;
        loadData   <= extracted;
      end
      if (timed_out) begin
        memRequest <= 1'b0;
        loadData   <= '0;
      end
    end
  end

  mips_memory_stage_lane u_lane (
    .req_size   (byteEnable),
    .req_lane   (address[1:0]),
    .store_data (storeData),
    .byte_mask  (mask_next),
    .write_data (wdata_next),
    .rsp_size   (size_q),
    .rsp_lane   (lane_q),
    .rsp_extend (extend_q),
    .read_data  (memReadData),
    .load_data  (extracted)
  );

endmodule

// File: tb/tb_mips_memory_stage_access.sv
// Self-checking bench for mips_memory_stage_access: directed vector table,
// hand-written reset/flush/misalign sequences, and randomized transactions.
module tb_mips_memory_stage_access;
  import mips_control_signal_memory_pkg::*;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid, flush, writeEnable, byteExtend;
  logic [1:0]  byteEnable;
  logic [31:0] address, storeData;
  logic        memRequest, memWrite;
  logic [31:0] memAddress, memWriteData;
  logic [3:0]  memByteMask;
  logic        memReady;
  logic [31:0] memReadData;
  logic        stall, doneValid, misaligned, busError;
  logic [31:0] loadData;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_memory_stage_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .flush(flush),
    .writeEnable(writeEnable), .byteEnable(byteEnable), .byteExtend(byteExtend),
    .address(address), .storeData(storeData), .memRequest(memRequest),
    .memWrite(memWrite), .memAddress(memAddress), .memByteMask(memByteMask),
    .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData),
    .stall(stall), .loadData(loadData), .doneValid(doneValid),
    .misaligned(misaligned), .busError(busError)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Reference model: byte count per size, then shift/mask arithmetic.
  function automatic int nbytes(input logic [1:0] be);
    return 1 << (int'(be) - 1);
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] be, input logic [31:0] a);
    logic [3:0] m = '0;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes(be)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] be, input logic [31:0] sd);
    logic [31:0] w = '0;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = sd >> (8 * (i % nbytes(be)));
      w[8*i +: 8] = t[7:0];
    end
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] be, input logic ext,
                                         input logic [31:0] a, input logic [31:0] rd);
    int bits = 8 * nbytes(be);
    logic [63:0] lim = (64'd1 << bits) - 64'd1;
    logic [63:0] v = 64'(rd >> (8 * (a % 4))) & lim;
    if (ext == BYTE_EXTEND_SIGNED && v[bits-1]) v = v | ~lim;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    inValid = 1'b0; flush = 1'b0; writeEnable = 1'b0; byteEnable = BYTE_ENABLE_NONE;
    byteExtend = 1'b0; address = '0; storeData = '0; memReady = 1'b0; memReadData = '0;
  endtask

  // One full access; ready_at = BUSY cycle carrying memReady, 0 = never (timeout).
  // Starts and ends just after a rising edge.
  task automatic run_txn(input string nm, input logic [1:0] be, input logic we, input logic ext,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                         input int ready_at, input bit flush_busy,
                         input logic [3:0] emask, input logic [31:0] ewd,
                         input logic [31:0] eload, input logic eberr);
    int busy_n = (ready_at == 0) ? TO : ready_at;
    inValid = 1'b1; flush = 1'b0; byteEnable = be; writeEnable = we; byteExtend = ext;
    address = addr; storeData = sd;
    memReady = 1'($urandom % 2); memReadData = $urandom;
    @(negedge clock);
    check({nm, " accept stall"}, 32'(stall), 32'd1);
    check({nm, " accept misaligned"}, 32'(misaligned), 32'd0);
    check({nm, " accept memRequest"}, 32'(memRequest), 32'd0);
    next_cycle();
    for (int c = 1; c <= busy_n; c++) begin
      flush       = flush_busy;
      memReady    = (c == ready_at);
      memReadData = (c == ready_at) ? rd : $urandom;
      @(negedge clock);
      check({nm, " busy stall"}, 32'(stall), 32'd1);
      check({nm, " busy memRequest"}, 32'(memRequest), 32'd1);
      check({nm, " busy doneValid"}, 32'(doneValid), 32'd0);
      if (c == 1) begin
        check({nm, " memAddress"}, memAddress, addr & ~32'd3);
        check({nm, " memByteMask"}, 32'(memByteMask), 32'(emask));
        check({nm, " memWriteData"}, memWriteData, ewd);
        check({nm, " memWrite"}, 32'(memWrite), 32'(we));
      end
      next_cycle();
    end
    flush = 1'b0; memReady = 1'($urandom % 2); memReadData = $urandom;
    @(negedge clock);
    check({nm, " done stall"}, 32'(stall), 32'd0);
    check({nm, " done doneValid"}, 32'(doneValid), 32'd1);
    check({nm, " done busError"}, 32'(busError), 32'(eberr));
    check({nm, " done memRequest"}, 32'(memRequest), 32'd0);
    check({nm, " loadData"}, loadData, eload);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    check({nm, " after doneValid"}, 32'(doneValid), 32'd0);
    check({nm, " after busError"}, 32'(busError), 32'd0);
    check({nm, " after memRequest"}, 32'(memRequest), 32'd0);
    check({nm, " after stall"}, 32'(stall), 32'd0);
    next_cycle();
  endtask

  typedef struct {
    string       name;
    logic [1:0]  be;
    logic        we;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          ready_at;
    bit          flush_busy;
    logic [3:0]  emask;
    logic [31:0] ewd;
    logic [31:0] eload;
    logic        eberr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"lb",      BYTE_ENABLE_BYTE, 1'b0, BYTE_EXTEND_SIGNED,   32'h0000_0103, 32'h0,
                32'h80FF_1234, 1, 1'b0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
    vecs[1] = '{"lhu",     BYTE_ENABLE_HALF, 1'b0, BYTE_EXTEND_UNSIGNED, 32'h0000_0102, 32'h0,
                32'h80FF_1234, 2, 1'b0, 4'b1100, 32'h0000_0000, 32'h0000_80FF, 1'b0};
    vecs[2] = '{"sb",      BYTE_ENABLE_BYTE, 1'b1, BYTE_EXTEND_SIGNED,   32'h0000_0001, 32'h0000_00A5,
                32'h80FF_1234, 4, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0012, 1'b0};
    vecs[3] = '{"lw_tmo",  BYTE_ENABLE_WORD, 1'b0, BYTE_EXTEND_SIGNED,   32'h0000_0200, 32'h0,
                32'h1234_5678, 0, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{"sh",      BYTE_ENABLE_HALF, 1'b1, BYTE_EXTEND_SIGNED,   32'h0000_0002, 32'h1234_BEEF,
                32'h7FFF_0000, 1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_7FFF, 1'b0};
    vecs[5] = '{"lw",      BYTE_ENABLE_WORD, 1'b0, BYTE_EXTEND_UNSIGNED, 32'h0000_0004, 32'h1122_3344,
                32'hDEAD_BEEF, 3, 1'b0, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{"lbu",     BYTE_ENABLE_BYTE, 1'b0, BYTE_EXTEND_UNSIGNED, 32'h0000_0000, 32'h0,
                32'h0000_00F0, 1, 1'b0, 4'b0001, 32'h0000_0000, 32'h0000_00F0, 1'b0};
    vecs[7] = '{"lw_flush", BYTE_ENABLE_WORD, 1'b0, BYTE_EXTEND_SIGNED,  32'h0000_0010, 32'h0,
                32'hCAFE_F00D, 3, 1'b1, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};

    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("reset memRequest", 32'(memRequest), 32'd0);
    check("reset memWrite", 32'(memWrite), 32'd0);
    check("reset memAddress", memAddress, 32'd0);
    check("reset memByteMask", 32'(memByteMask), 32'd0);
    check("reset memWriteData", memWriteData, 32'd0);
    check("reset loadData", loadData, 32'd0);
    check("reset doneValid", 32'(doneValid), 32'd0);
    check("reset busError", 32'(busError), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].be, vecs[i].we, vecs[i].ext, vecs[i].addr, vecs[i].sd,
              vecs[i].rd, vecs[i].ready_at, vecs[i].flush_busy, vecs[i].emask, vecs[i].ewd,
              vecs[i].eload, vecs[i].eberr);

    // Misaligned halfword: flagged, never requests the bus, no stall.
    inValid = 1'b1; byteEnable = BYTE_ENABLE_HALF; address = 32'h0000_1001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("lh misaligned", 32'(misaligned), 32'd1);
      check("lh misaligned stall", 32'(stall), 32'd0);
      check("lh misaligned memRequest", 32'(memRequest), 32'd0);
      next_cycle();
    end
    byteEnable = BYTE_ENABLE_WORD; address = 32'h0000_0002;
    @(negedge clock);
    check("lw misaligned", 32'(misaligned), 32'd1);
    check("lw misaligned stall", 32'(stall), 32'd0);
    next_cycle();
    // Flush in IDLE blocks the accept.
    address = 32'h0000_0000; flush = 1'b1;
    @(negedge clock);
    check("flush idle stall", 32'(stall), 32'd0);
    check("flush idle misaligned", 32'(misaligned), 32'd0);
    next_cycle();
    @(negedge clock);
    check("flush idle memRequest", 32'(memRequest), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Reset on the second BUSY cycle abandons the access.
    inValid = 1'b1; byteEnable = BYTE_ENABLE_WORD; address = 32'h0000_0040;
    next_cycle();
    @(negedge clock);
    check("rst busy1 memRequest", 32'(memRequest), 32'd1);
    next_cycle();
    reset = 1'b1; inValid = 1'b0;
    @(negedge clock);
    check("rst busy2 stall", 32'(stall), 32'd1);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("rst after memRequest", 32'(memRequest), 32'd0);
    check("rst after stall", 32'(stall), 32'd0);
    check("rst after memAddress", memAddress, 32'd0);
    check("rst after memByteMask", 32'(memByteMask), 32'd0);
    check("rst after loadData", loadData, 32'd0);
    check("rst after doneValid", 32'(doneValid), 32'd0);
    check("rst after busError", 32'(busError), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Randomized aligned accesses checked against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  be   = 2'($urandom_range(1, 3));
      logic        we   = 1'($urandom % 2);
      logic        ext  = 1'($urandom % 2);
      logic [31:0] addr = $urandom & ~32'(nbytes(be) - 1);
      logic [31:0] sd   = $urandom;
      logic [31:0] rd   = $urandom;
      int          rdy  = $urandom_range(0, TO);
      bit          fl   = ($urandom % 4) == 0;
      run_txn($sformatf("rnd%0d", n), be, we, ext, addr, sd, rd, rdy, fl,
              m_mask(be, addr), m_wdata(be, sd),
              (rdy == 0) ? 32'd0 : m_load(be, ext, addr, rd), rdy == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
